// File: rtl/mips_pkg.sv
// Shared write-back definitions: register file geometry, requester ids and request bundle.
package mips_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_LOAD   = 2'd1;
  localparam logic [1:0] WB_MULDIV = 2'd2;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] regAddr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [1:0] rrNext(input logic [1:0] idx);
    case (idx)
      WB_ALU:  return WB_LOAD;
      WB_LOAD: return WB_MULDIV;
      default: return WB_ALU;
    endcase
  endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// Three-way one-hot arbiter with round-robin pointer or fixed priority (requester 0 first).
module rr_arbiter3
  import mips_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_stall,
  input  logic [2:0] i_valid,
  output logic [2:0] o_grant,
  output logic [1:0] o_winner
);

  logic [1:0] r_ptr;
  logic [1:0] w_idx;
  logic [1:0] w_winner;
  logic       w_found;
  logic [2:0] w_grant;

  // Fixed priority is round-robin search anchored at requester 0.
  always_comb begin
    w_grant  = '0;
    w_winner = WB_ALU;
    w_found  = 1'b0;
    w_idx    = (PRIORITY_MODE == 1) ? WB_ALU : r_ptr;
    if (i_rst_n && !i_stall) begin
      for (int k = 0; k < 3; k++) begin
        if (!w_found && i_valid[w_idx]) begin
          w_found  = 1'b1;
          w_winner = w_idx;
        end
        w_idx = rrNext(w_idx);
      end
    end
    if (w_found) w_grant[w_winner] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ptr <= WB_ALU;
    end else if (w_found) begin
      r_ptr <= rrNext(w_winner);
    end
  end

  assign o_grant  = w_grant;
  assign o_winner = w_winner;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates three write-back requesters onto the register file write port through a
// one-cycle registered output stage, and exports the pending-destination mask.
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int PRIORITY_MODE = 0,
  parameter int ADDR_W        = 5,
  parameter int DATA_W        = 32
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic [NUM_REQ-1:0]        Req_Valid,
  input  logic [NUM_REQ*ADDR_W-1:0] Req_Reg,
  input  logic [NUM_REQ*DATA_W-1:0] Req_Data,
  output logic [NUM_REQ-1:0]        Req_Ready,
  input  logic                      Stall,
  output logic [ADDR_W-1:0]         Write_Reg,
  output logic [DATA_W-1:0]         Write_Data,
  output logic                      RegWrite,
  output logic [1:0]                Grant_Id,
  output logic [2**ADDR_W-1:0]      Pending_Mask
);

  wb_req_t w_req [3];
  logic [2:0] w_grant;
  logic [1:0] w_winner;
  logic [2**ADDR_W-1:0] w_pendingMask;

  logic              r_regWrite;
  logic [ADDR_W-1:0] r_writeReg;
  logic [DATA_W-1:0] r_writeData;
  logic [1:0]        r_grantId;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w_req[i].valid   = Req_Valid[i];
      w_req[i].regAddr = Req_Reg[i*ADDR_W +: ADDR_W];
      w_req[i].data    = Req_Data[i*DATA_W +: DATA_W];
    end
  end

  rr_arbiter3 #(.PRIORITY_MODE(PRIORITY_MODE)) u_arb (
    .i_clk    (Clk),
    .i_rst_n  (Rst_n),
    .i_stall  (Stall),
    .i_valid  (Req_Valid),
    .o_grant  (w_grant),
    .o_winner (w_winner)
  );

  // Writes to register 0 are accepted and latched but never enabled.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_regWrite  <= 1'b0;
      r_writeReg  <= '0;
      r_writeData <= '0;
      r_grantId   <= WB_ALU;
    end else begin
      r_regWrite <= 1'b0;
      if (|w_grant) begin
        r_regWrite  <= (w_req[w_winner].regAddr != '0);
        r_writeReg  <= w_req[w_winner].regAddr;
        r_writeData <= w_req[w_winner].data;
        r_grantId   <= w_winner;
      end
    end
  end

  always_comb begin
    w_pendingMask = '0;
    for (int i = 0; i < 3; i++) begin
      if (w_req[i].valid) w_pendingMask[w_req[i].regAddr] = 1'b1;
    end
    if (r_regWrite) w_pendingMask[r_writeReg] = 1'b1;
    w_pendingMask[0] = 1'b0;
  end

  assign Req_Ready    = w_grant;
  assign RegWrite     = r_regWrite;
  assign Write_Reg    = r_writeReg;
  assign Write_Data   = r_writeData;
  assign Grant_Id     = r_grantId;
  assign Pending_Mask = w_pendingMask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench: stimulus pushes expected register writes into a queue that a negedge
// monitor pops against the output stage; a second instance exercises fixed priority.
module tb_regfile_wb_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [2:0]  Req_Valid;
  logic [14:0] Req_Reg;
  logic [95:0] Req_Data;
  logic [2:0]  Req_Ready;
  logic        Stall;
  logic [4:0]  Write_Reg;
  logic [31:0] Write_Data;
  logic        RegWrite;
  logic [1:0]  Grant_Id;
  logic [31:0] Pending_Mask;

  logic [2:0]  fValid;
  logic [14:0] fReg;
  logic [95:0] fData;
  logic [2:0]  fReady;
  logic [4:0]  fWriteReg;
  logic [31:0] fWriteData;
  logic        fRegWrite;
  logic [1:0]  fGrantId;
  logic [31:0] fMask;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  id;
    int          cyc;
  } exp_t;

  exp_t expQ[$];
  int   tests = 0;
  int   failures = 0;
  int   cycCount = 0;

  always #5 Clk = ~Clk;

  regfile_wb_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n), .Req_Valid(Req_Valid), .Req_Reg(Req_Reg),
    .Req_Data(Req_Data), .Req_Ready(Req_Ready), .Stall(Stall),
    .Write_Reg(Write_Reg), .Write_Data(Write_Data), .RegWrite(RegWrite),
    .Grant_Id(Grant_Id), .Pending_Mask(Pending_Mask)
  );

  regfile_wb_arbiter #(.PRIORITY_MODE(1)) fDut (
    .Clk(Clk), .Rst_n(Rst_n), .Req_Valid(fValid), .Req_Reg(fReg),
    .Req_Data(fData), .Req_Ready(fReady), .Stall(1'b0),
    .Write_Reg(fWriteReg), .Write_Data(fWriteData), .RegWrite(fRegWrite),
    .Grant_Id(fGrantId), .Pending_Mask(fMask)
  );

  always @(posedge Clk) cycCount++;

  // Every due expectation must meet a RegWrite pulse, and every pulse must be expected.
  always @(negedge Clk) begin
    if (expQ.size() > 0 && expQ[0].cyc == cycCount) begin
      exp_t e;
      e = expQ.pop_front();
      tests++;
      if (RegWrite !== 1'b1 || Write_Reg !== e.rd || Write_Data !== e.data || Grant_Id !== e.id) begin
        failures++;
        $display("[TB] FAIL wb_write: got RegWrite=%b reg=%0d data=%h id=%0d, expected RegWrite=1 reg=%0d data=%h id=%0d",
                 RegWrite, Write_Reg, Write_Data, Grant_Id, e.rd, e.data, e.id);
      end
    end else if (RegWrite === 1'b1) begin
      tests++;
      failures++;
      $display("[TB] FAIL unexpected_write: got reg=%0d data=%h id=%0d, expected no write",
               Write_Reg, Write_Data, Grant_Id);
    end
  end

  task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task applyStimulus(input logic [2:0] v, input logic [14:0] regs, input logic [95:0] data,
                     input logic stall);
    Req_Valid = v;
    Req_Reg   = regs;
    Req_Data  = data;
    Stall     = stall;
  endtask

  // Checks the combinational grant of the current cycle and queues the write it should cause.
  task runCycle(input string name, input logic [2:0] expReady, input logic pushWrite,
                input logic checkMask, input logic [31:0] expMask);
    int   w;
    exp_t e;
    #1;
    checkOutput({name, "_ready"}, {29'd0, Req_Ready}, {29'd0, expReady});
    if (checkMask) checkOutput({name, "_mask"}, Pending_Mask, expMask);
    if (pushWrite && expReady != 3'b000) begin
      w      = expReady[0] ? 0 : (expReady[1] ? 1 : 2);
      e.rd   = Req_Reg[w*5 +: 5];
      e.data = Req_Data[w*32 +: 32];
      e.id   = 2'(w);
      e.cyc  = cycCount + 1;
      if (e.rd != 5'd0) expQ.push_back(e);
    end
    @(posedge Clk);
    #1;
  endtask

  localparam logic [14:0] REGS_123 = {5'd3, 5'd2, 5'd1};
  localparam logic [95:0] DATA_ABC = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000};

  initial begin
    Rst_n  = 1'b0;
    fValid = 3'b000;
    fReg   = '0;
    fData  = '0;
    applyStimulus(3'b111, REGS_123, DATA_ABC, 1'b0);

    @(posedge Clk);
    #1;
    checkOutput("reset_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("reset_write_reg", {27'd0, Write_Reg}, 32'd0);
    checkOutput("reset_write_data", Write_Data, 32'd0);
    checkOutput("reset_grant_id", {30'd0, Grant_Id}, 32'd0);
    runCycle("reset0", 3'b000, 1'b1, 1'b0, 32'd0);
    runCycle("reset1", 3'b000, 1'b1, 1'b0, 32'd0);

    Rst_n = 1'b1;
    runCycle("rr_g0", 3'b001, 1'b1, 1'b1, 32'h0000_000E);
    runCycle("rr_g1", 3'b010, 1'b1, 1'b1, 32'h0000_000E);
    runCycle("rr_g2", 3'b100, 1'b1, 1'b0, 32'd0);
    runCycle("rr_g3", 3'b001, 1'b1, 1'b0, 32'd0);
    applyStimulus(3'b000, '0, '0, 1'b0);
    runCycle("idle_a", 3'b000, 1'b1, 1'b1, 32'h0000_0002);

    applyStimulus(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0}, 1'b0);
    runCycle("single", 3'b010, 1'b1, 1'b1, 32'h0000_0020);
    applyStimulus(3'b000, '0, '0, 1'b0);
    checkOutput("single_regwrite", {31'd0, RegWrite}, 32'd1);
    checkOutput("single_write_reg", {27'd0, Write_Reg}, 32'd5);
    checkOutput("single_write_data", Write_Data, 32'hDEAD_BEEF);
    checkOutput("single_grant_id", {30'd0, Grant_Id}, 32'd1);
    runCycle("single_idle", 3'b000, 1'b1, 1'b1, 32'h0000_0020);
    checkOutput("single_regwrite_off", {31'd0, RegWrite}, 32'd0);

    applyStimulus(3'b001, {5'd0, 5'd0, 5'd0}, {32'd0, 32'd0, 32'd7}, 1'b0);
    runCycle("reg0", 3'b001, 1'b1, 1'b1, 32'd0);
    applyStimulus(3'b000, '0, '0, 1'b0);
    checkOutput("reg0_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("reg0_write_reg", {27'd0, Write_Reg}, 32'd0);
    checkOutput("reg0_write_data", Write_Data, 32'd7);
    runCycle("reg0_idle", 3'b000, 1'b1, 1'b1, 32'd0);

    applyStimulus(3'b100, {5'd4, 5'd0, 5'd0}, {32'h44, 32'd0, 32'd0}, 1'b0);
    runCycle("ptr_to0", 3'b100, 1'b1, 1'b1, 32'h0000_0010);
    applyStimulus(3'b101, {5'd9, 5'd0, 5'd9}, {32'd2, 32'd0, 32'd1}, 1'b0);
    runCycle("same_a", 3'b001, 1'b1, 1'b1, 32'h0000_0210);
    applyStimulus(3'b100, {5'd9, 5'd0, 5'd0}, {32'd2, 32'd0, 32'd0}, 1'b0);
    runCycle("same_b", 3'b100, 1'b1, 1'b1, 32'h0000_0200);
    applyStimulus(3'b000, '0, '0, 1'b0);
    runCycle("same_c", 3'b000, 1'b1, 1'b1, 32'h0000_0200);
    runCycle("same_d", 3'b000, 1'b1, 1'b1, 32'd0);

    applyStimulus(3'b111, {5'd12, 5'd11, 5'd10}, {32'hA2, 32'hA1, 32'hA0}, 1'b0);
    runCycle("stall_pre", 3'b001, 1'b1, 1'b0, 32'd0);
    Stall = 1'b1;
    for (int k = 0; k < 4; k++) runCycle("stall", 3'b000, 1'b1, 1'b0, 32'd0);
    Stall = 1'b0;
    runCycle("resume0", 3'b010, 1'b1, 1'b0, 32'd0);
    runCycle("resume1", 3'b100, 1'b1, 1'b0, 32'd0);
    runCycle("resume2", 3'b001, 1'b1, 1'b0, 32'd0);
    applyStimulus(3'b000, '0, '0, 1'b0);
    runCycle("resume_idle0", 3'b000, 1'b1, 1'b0, 32'd0);
    runCycle("resume_idle1", 3'b000, 1'b1, 1'b0, 32'd0);

    applyStimulus(3'b010, {5'd0, 5'd13, 5'd0}, {32'd0, 32'h0D, 32'd0}, 1'b0);
    runCycle("midrst_grant", 3'b010, 1'b1, 1'b0, 32'd0);
    Rst_n = 1'b0;
    runCycle("midrst_low", 3'b000, 1'b1, 1'b0, 32'd0);
    checkOutput("midrst_regwrite", {31'd0, RegWrite}, 32'd0);
    checkOutput("midrst_write_reg", {27'd0, Write_Reg}, 32'd0);
    Rst_n = 1'b1;
    applyStimulus(3'b111, REGS_123, DATA_ABC, 1'b0);
    runCycle("midrst_ptr", 3'b001, 1'b1, 1'b0, 32'd0);
    applyStimulus(3'b000, '0, '0, 1'b0);
    runCycle("midrst_idle", 3'b000, 1'b1, 1'b0, 32'd0);

    fValid = 3'b101;
    fReg   = {5'd7, 5'd0, 5'd6};
    fData  = {32'h77, 32'd0, 32'h66};
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("fixed_ready", {29'd0, fReady}, 32'd1);
      @(posedge Clk);
      #1;
      checkOutput("fixed_regwrite", {31'd0, fRegWrite}, 32'd1);
      checkOutput("fixed_write_reg", {27'd0, fWriteReg}, 32'd6);
      checkOutput("fixed_grant_id", {30'd0, fGrantId}, 32'd0);
    end
    fValid = 3'b000;

    runCycle("drain0", 3'b000, 1'b1, 1'b0, 32'd0);
    runCycle("drain1", 3'b000, 1'b1, 1'b0, 32'd0);
    checkOutput("scoreboard_empty", expQ.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
